// File: rtl/ps2_keyboard_decoder.sv
// PS/2 set-2 keyboard receiver and scan-code to ASCII decoder with Shift/Caps Lock tracking.
// One valid pulse per printable make code (auto-repeats included); frame_err pulses on bad frames.
module ps2_keyboard_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic [7:0] ascii_key_o,
   output logic [7:0] scancode_o,
   output logic       valid_o,
   output logic       caps_lock_o,
   output logic       frame_err_o
);

   typedef enum logic [1:0] {
      ST_NORMAL  = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } dec_state_e;

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [2:0]    clk_sync_q, data_sync_q;
   logic [3:0]    count_q, count_d;
   logic [7:0]    sreg_q, sreg_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] timer_q, timer_d;
   dec_state_e    state_q, state_d;
   logic          shift_q, shift_d, caps_q, caps_d, held_q, held_d;
   logic [7:0]    ascii_q, ascii_d, scan_q, scan_d;
   logic          valid_q, valid_d, err_q, err_d;
   logic          fall_s, bit_s, byte_rdy_s;
   logic [7:0]    letter_s, lut_s;
   logic [15:0]   sym_s;

   function automatic logic [7:0] letter_lut(input logic [7:0] code);
      case (code)
         8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;  8'h23: return 8'h64;
         8'h24: return 8'h65;  8'h2B: return 8'h66;  8'h34: return 8'h67;  8'h33: return 8'h68;
         8'h43: return 8'h69;  8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
         8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;  8'h4D: return 8'h70;
         8'h15: return 8'h71;  8'h2D: return 8'h72;  8'h1B: return 8'h73;  8'h2C: return 8'h74;
         8'h3C: return 8'h75;  8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
         8'h35: return 8'h79;  8'h1A: return 8'h7A;
         default: return 8'h00;
      endcase
   endfunction

   // {unshifted, shifted}; control keys carry the same code in both halves
   function automatic logic [15:0] symbol_lut(input logic [7:0] code);
      case (code)
         8'h16: return 16'h3121;  8'h1E: return 16'h3240;  8'h26: return 16'h3323;
         8'h25: return 16'h3424;  8'h2E: return 16'h3525;  8'h36: return 16'h365E;
         8'h3D: return 16'h3726;  8'h3E: return 16'h382A;  8'h46: return 16'h3928;
         8'h45: return 16'h3029;  8'h4E: return 16'h2D5F;  8'h55: return 16'h3D2B;
         8'h54: return 16'h5B7B;  8'h5B: return 16'h5D7D;  8'h5D: return 16'h5C7C;
         8'h4C: return 16'h3B3A;  8'h52: return 16'h2722;  8'h41: return 16'h2C3C;
         8'h49: return 16'h2E3E;  8'h4A: return 16'h2F3F;  8'h0E: return 16'h607E;
         8'h29: return 16'h2020;  8'h5A: return 16'h0D0D;  8'h66: return 16'h0808;
         8'h0D: return 16'h0909;
         default: return 16'h0000;
      endcase
   endfunction

   assign fall_s   = clk_sync_q[2] & ~clk_sync_q[1];
   assign bit_s    = data_sync_q[1];
   assign letter_s = letter_lut(sreg_q);
   assign sym_s    = symbol_lut(sreg_q);

   // ASCII lookup of the byte held in the shift register
   always_comb begin
      lut_s = 8'h00;
      if (letter_s != 8'h00) begin
         lut_s = (shift_q ^ caps_q) ? (letter_s - 8'h20) : letter_s;
      end else if (shift_q) begin
         lut_s = sym_s[7:0];
      end else begin
         lut_s = sym_s[15:8];
      end
   end

   // Frame receiver: bit counter, shift register, parity/stop check and idle timeout
   always_comb begin
      count_d    = count_q;
      sreg_d     = sreg_q;
      parity_d   = parity_q;
      timer_d    = timer_q;
      err_d      = 1'b0;
      byte_rdy_s = 1'b0;
      if (fall_s) begin
         timer_d = '0;
         case (count_q)
            4'd0: begin
               if (!bit_s) count_d = 4'd1;
               else        count_d = 4'd0;
            end
            4'd9: begin
               parity_d = bit_s;
               count_d  = 4'd10;
            end
            4'd10: begin
               count_d = 4'd0;
               if ((^{sreg_q, parity_q}) && bit_s) byte_rdy_s = 1'b1;
               else                                err_d      = 1'b1;
            end
            default: begin
               sreg_d  = {bit_s, sreg_q[7:1]};
               count_d = count_q + 4'd1;
            end
         endcase
      end else if (count_q != 4'd0) begin
         if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            count_d = 4'd0;
            timer_d = '0;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end else begin
         timer_d = '0;
      end
   end

   // Prefix FSM, modifier tracking and output selection for each received byte
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      caps_d  = caps_q;
      held_d  = held_q;
      ascii_d = ascii_q;
      scan_d  = scan_q;
      valid_d = 1'b0;
      if (byte_rdy_s) begin
         case (state_q)
            ST_NORMAL: begin
               if (sreg_q == 8'hF0) begin
                  state_d = ST_BRK;
               end else if (sreg_q == 8'hE0) begin
                  state_d = ST_EXT;
               end else if (sreg_q == 8'h12 || sreg_q == 8'h59) begin
                  shift_d = 1'b1;
               end else if (sreg_q == 8'h58) begin
                  caps_d = held_q ? caps_q : ~caps_q;
                  held_d = 1'b1;
               end else if (lut_s != 8'h00) begin
                  ascii_d = lut_s;
                  scan_d  = sreg_q;
                  valid_d = 1'b1;
               end else begin
                  state_d = ST_NORMAL;
               end
            end
            ST_BRK: begin
               state_d = ST_NORMAL;
               if (sreg_q == 8'h12 || sreg_q == 8'h59) begin
                  shift_d = 1'b0;
               end else if (sreg_q == 8'h58) begin
                  held_d = 1'b0;
               end else begin
                  held_d = held_q;
               end
            end
            ST_EXT: begin
               if (sreg_q == 8'hF0) state_d = ST_EXT_BRK;
               else                 state_d = ST_NORMAL;
            end
            ST_EXT_BRK: state_d = ST_NORMAL;
            default:    state_d = ST_NORMAL;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clk_sync_q  <= 3'b111;
         data_sync_q <= 3'b111;
         count_q     <= 4'd0;
         sreg_q      <= 8'h00;
         parity_q    <= 1'b0;
         timer_q     <= '0;
         state_q     <= ST_NORMAL;
         shift_q     <= 1'b0;
         caps_q      <= 1'b0;
         held_q      <= 1'b0;
         ascii_q     <= 8'h00;
         scan_q      <= 8'h00;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
         data_sync_q <= {data_sync_q[1:0], ps2_data_i};
         count_q     <= count_d;
         sreg_q      <= sreg_d;
         parity_q    <= parity_d;
         timer_q     <= timer_d;
         state_q     <= state_d;
         shift_q     <= shift_d;
         caps_q      <= caps_d;
         held_q      <= held_d;
         ascii_q     <= ascii_d;
         scan_q      <= scan_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   assign ascii_key_o = ascii_q;
   assign scancode_o  = scan_q;
   assign valid_o     = valid_q;
   assign caps_lock_o = caps_q;
   assign frame_err_o = err_q;

endmodule
